dtack_generator: RTL and testbench

- Bus-cycle acknowledge stage directly downstream of the CPU address decoder.
- Consumes the decoder's per-region select strobes plus the 68k bus strobes (AS_L, UDS_L, LDS_L).
- Inserts a per-region programmable wait-state count, or waits for the DRAM controller's handshake.
- Drives DTACK_L back to the CPU and, optionally, BERR_L on a bus timeout.

---
 rtl/dtack_generator.sv | 181 ++++++++++++++++++
 tb/tb_dtack_generator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtack_generator.sv
// 68k DTACK/BERR generator: per-region wait states or DRAM handshake.
// Optional bus timeout with BERR_L enabled by defining BUS_TIMEOUT_EN.
module dtack_generator #(
   parameter int unsigned ROM_WAIT = 1,
   parameter int unsigned RAM_WAIT = 1,
   parameter int unsigned IO_WAIT  = 2,
   parameter int unsigned GFX_WAIT = 3,
   parameter int unsigned CNT_W    = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic Clock,
   input  logic Reset_H,
   input  logic AS_L,
   input  logic UDS_L,
   input  logic LDS_L,
   input  logic OnChipRomSelect_H,
   input  logic OnChipRamSelect_H,
   input  logic DramSelect_H,
   input  logic IOSelect_H,
   input  logic GraphicsCS_L,
   input  logic wrencursor,
   input  logic VoiceControl_H,
   input  logic DramDtack_L,
   output logic DTACK_L,
   output logic BERR_L,
   output logic Busy_H
);

   localparam int unsigned WaitMax = (1 << CNT_W) - 1;

   if (ROM_WAIT > WaitMax || RAM_WAIT > WaitMax ||
       IO_WAIT > WaitMax || GFX_WAIT > WaitMax ||
       TIMEOUT == 0) begin : gBadParam
      $error("dtack_generator: wait value exceeds counter or zero timeout");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      DRAMWAIT,
`ifdef BUS_TIMEOUT_EN
      ERR,
`endif
      ACK
   } state_t;

   state_t state, nextState;

   logic [CNT_W-1:0] waitCnt;
   logic             mapped;
   logic             startCycle;
   logic             selDram;
   logic             selMapped;
   logic [CNT_W-1:0] selWait;
   logic             gfxSel;
   logic             dtackNext;

`ifdef BUS_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] toCnt;
   logic            timedOut;
   logic            berrNext;

   assign timedOut = (toCnt == TO_W'(TIMEOUT));
`endif

   assign startCycle = !AS_L && (!UDS_L || !LDS_L);
   // GraphicsCS_L is driven high by the decoder when selected
   assign gfxSel = GraphicsCS_L || wrencursor || VoiceControl_H;

   always_comb begin
      selDram   = 1'b0;
      selMapped = 1'b1;
      selWait   = '0;
      if (OnChipRomSelect_H)
         selWait = CNT_W'(ROM_WAIT);
      else if (OnChipRamSelect_H)
         selWait = CNT_W'(RAM_WAIT);
      else if (DramSelect_H)
         selDram = 1'b1;
      else if (IOSelect_H)
         selWait = CNT_W'(IO_WAIT);
      else if (gfxSel)
         selWait = CNT_W'(GFX_WAIT);
      else
         selMapped = 1'b0;
   end

   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H)
         state <= IDLE;
      else
         state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: begin
            if (startCycle)
               nextState = selDram ? DRAMWAIT : WAIT;
         end
         WAIT: begin
            if (AS_L)
               nextState = IDLE;
            else if (mapped && waitCnt == '0)
               nextState = ACK;
`ifdef BUS_TIMEOUT_EN
            else if (timedOut)
               nextState = ERR;
`endif
         end
         DRAMWAIT: begin
            if (AS_L)
               nextState = IDLE;
            else if (!DramDtack_L)
               nextState = ACK;
`ifdef BUS_TIMEOUT_EN
            else if (timedOut)
               nextState = ERR;
`endif
         end
`ifdef BUS_TIMEOUT_EN
         ERR: begin
            if (AS_L)
               nextState = IDLE;
         end
`endif
         ACK: begin
            if (AS_L)
               nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_comb begin
      Busy_H    = (state != IDLE);
      dtackNext = (nextState != ACK);
`ifdef BUS_TIMEOUT_EN
      berrNext  = (nextState != ERR);
`endif
   end

   // region is latched at the start edge; later select changes are ignored
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         waitCnt <= '0;
         mapped  <= 1'b0;
         DTACK_L <= 1'b1;
      end else begin
         DTACK_L <= dtackNext;
         if (state == IDLE) begin
            if (startCycle) begin
               waitCnt <= selWait;
               mapped  <= selMapped;
            end
         end else if (state == WAIT && waitCnt != '0) begin
            waitCnt <= waitCnt - 1'b1;
         end
      end
   end

`ifdef BUS_TIMEOUT_EN
   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         toCnt  <= '0;
         BERR_L <= 1'b1;
      end else begin
         BERR_L <= berrNext;
         if (state == WAIT || state == DRAMWAIT)
            toCnt <= toCnt + 1'b1;
         else
            toCnt <= '0;
      end
   end
`else
   assign BERR_L = 1'b1;
`endif

endmodule

// File: tb/tb_dtack_generator.sv
// Scoreboard bench for dtack_generator: expected {DTACK_L,BERR_L,Busy_H}
// per edge are queued with the stimulus and popped at each sample point.
module tb_dtack_generator;

   logic Clock = 1'b0;
   logic Reset_H;
   logic AS_L, UDS_L, LDS_L;
   logic OnChipRomSelect_H, OnChipRamSelect_H, DramSelect_H;
   logic IOSelect_H, GraphicsCS_L, wrencursor, VoiceControl_H;
   logic DramDtack_L;
   logic DTACK_L, BERR_L, Busy_H;

   logic [2:0] expQ[$];
   logic [2:0] exp;
   int tests = 0;
   int fails = 0;

   dtack_generator #(
      .ROM_WAIT(1), .RAM_WAIT(1), .IO_WAIT(2), .GFX_WAIT(3),
      .CNT_W(4), .TIMEOUT(16)
   ) dut (
      .Clock(Clock),
      .Reset_H(Reset_H),
      .AS_L(AS_L),
      .UDS_L(UDS_L),
      .LDS_L(LDS_L),
      .OnChipRomSelect_H(OnChipRomSelect_H),
      .OnChipRamSelect_H(OnChipRamSelect_H),
      .DramSelect_H(DramSelect_H),
      .IOSelect_H(IOSelect_H),
      .GraphicsCS_L(GraphicsCS_L),
      .wrencursor(wrencursor),
      .VoiceControl_H(VoiceControl_H),
      .DramDtack_L(DramDtack_L),
      .DTACK_L(DTACK_L),
      .BERR_L(BERR_L),
      .Busy_H(Busy_H)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idleBus();
      AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
      OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0;
      DramSelect_H = 1'b0; IOSelect_H = 1'b0;
      GraphicsCS_L = 1'b0; wrencursor = 1'b0;
      VoiceControl_H = 1'b0; DramDtack_L = 1'b1;
   endtask

   task automatic test_reset();
      Reset_H = 1'b1;
      idleBus();
      #2;
      expQ.push_back(3'b110);
      exp = expQ.pop_front(); tests++;
      if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
         fails++;
         $display("FAIL reset_initial: got %b want %b", {DTACK_L, BERR_L, Busy_H}, exp);
      end
      tick();
      Reset_H = 1'b0;
      tick();
      OnChipRomSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
      expQ.push_back(3'b011);
      expQ.push_back(3'b110);
      tick(); tick(); tick();
      exp = expQ.pop_front(); tests++;
      if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
         fails++;
         $display("FAIL reset_pre_ack: got %b want %b", {DTACK_L, BERR_L, Busy_H}, exp);
      end
      #2 Reset_H = 1'b1;
      #1;
      exp = expQ.pop_front(); tests++;
      if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
         fails++;
         $display("FAIL reset_mid_ack: got %b want %b", {DTACK_L, BERR_L, Busy_H}, exp);
      end
      idleBus();
      tick();
      Reset_H = 1'b0;
      tick();
   endtask

   task automatic test_rom();
      OnChipRomSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
      for (int e = 0; e <= 6; e++)
         expQ.push_back({!(e >= 2 && e <= 4), 1'b1, (e <= 4)});
      for (int e = 0; e <= 6; e++) begin
         if (e == 5) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL rom edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_gfx();
      GraphicsCS_L = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
      for (int e = 0; e <= 7; e++)
         expQ.push_back({!(e >= 4 && e <= 5), 1'b1, (e <= 5)});
      for (int e = 0; e <= 7; e++) begin
         if (e == 6) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL gfx edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_io_priority();
      IOSelect_H = 1'b1; GraphicsCS_L = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
      for (int e = 0; e <= 6; e++)
         expQ.push_back({!(e >= 3 && e <= 4), 1'b1, (e <= 4)});
      for (int e = 0; e <= 6; e++) begin
         if (e == 1) begin
            IOSelect_H = 1'b0; OnChipRomSelect_H = 1'b1;
         end
         if (e == 5) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL io_prio edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_ram_over_dram();
      OnChipRamSelect_H = 1'b1; DramSelect_H = 1'b1;
      AS_L = 1'b0; UDS_L = 1'b0;
      for (int e = 0; e <= 4; e++)
         expQ.push_back({!(e >= 2 && e <= 2), 1'b1, (e <= 2)});
      for (int e = 0; e <= 4; e++) begin
         if (e == 3) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL ram_prio edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_dram();
      DramSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
      for (int e = 0; e <= 11; e++)
         expQ.push_back({!(e >= 8 && e <= 9), 1'b1, (e <= 9)});
      for (int e = 0; e <= 11; e++) begin
         if (e == 8) DramDtack_L = 1'b0;
         if (e == 10) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL dram edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_dram_abort();
      DramSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
      for (int e = 0; e <= 8; e++)
         expQ.push_back({1'b1, 1'b1, (e <= 3)});
      for (int e = 0; e <= 8; e++) begin
         if (e == 4) idleBus();
         if (e == 5) DramDtack_L = 1'b0;
         if (e == 7) DramDtack_L = 1'b1;
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL dram_abort edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   task automatic test_no_data_strobe();
      OnChipRomSelect_H = 1'b1; AS_L = 1'b0;
      for (int e = 0; e <= 3; e++)
         expQ.push_back(3'b110);
      for (int e = 0; e <= 3; e++) begin
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL no_strobe edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
      idleBus();
      tick();
   endtask

   task automatic test_unmapped();
`ifdef BUS_TIMEOUT_EN
      AS_L = 1'b0; UDS_L = 1'b0;
      for (int e = 0; e <= 21; e++)
         expQ.push_back({1'b1, !(e >= 17 && e <= 19), (e <= 19)});
      for (int e = 0; e <= 21; e++) begin
         if (e == 20) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL timeout edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
`else
      AS_L = 1'b0; UDS_L = 1'b0;
      for (int e = 0; e <= 301; e++)
         expQ.push_back({1'b1, 1'b1, (e <= 299)});
      for (int e = 0; e <= 301; e++) begin
         if (e == 300) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL unmapped edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
`endif
   endtask

   task automatic test_back_to_back();
      OnChipRomSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
      for (int e = 0; e <= 8; e++)
         expQ.push_back({!(e == 2 || e == 6), 1'b1, (e != 3 && e < 7)});
      for (int e = 0; e <= 8; e++) begin
         if (e == 3) AS_L = 1'b1;
         if (e == 4) begin
            AS_L = 1'b0; UDS_L = 1'b1;
         end
         if (e == 7) idleBus();
         tick();
         exp = expQ.pop_front(); tests++;
         if ({DTACK_L, BERR_L, Busy_H} !== exp) begin
            fails++;
            $display("FAIL b2b edge %0d: got %b want %b", e, {DTACK_L, BERR_L, Busy_H}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_rom();
      test_gfx();
      test_io_priority();
      test_ram_over_dram();
      test_dram();
      test_dram_abort();
      test_no_data_strobe();
      test_unmapped();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
